ddr_port_arbiter: RTL

- Shares the single block-level port of ddr_ctrl (ram_en / ram_write / ram_addr / data_to_ram / ram_rdy / block read bus) between NREQ requesters, e.g. D-cache writeback, D-cache refill, I-cache refill and loader DMA.
- Sits between the cache/loader side and ddr_ctrl, in the clk_pipeline domain.
- Arbitration is round-robin, with an optional write-first override.
- Latches the winner's command, sequences exactly one 256-bit DDR transaction at a time, and returns read data with a done pulse.

---
 rtl/ddr_arb_pkg.sv | 13 +
 rtl/ddr_port_arbiter_rr_pick.sv | 27 ++
 rtl/ddr_port_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the DDR block-port arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ARB_ADDR_W  = 30;
  localparam int ARB_BLOCK_W = 256;

endpackage

// File: rtl/ddr_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first candidate at or after ptr (mod NREQ) wins, one-hot.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  cand,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win
);

  int unsigned pos;
  logic        found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(ptr) + k) % NREQ;
      if (!found && cand[PTR_W'(pos)]) begin
        win[PTR_W'(pos)] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin (optionally write-first) arbiter sharing the ddr_ctrl block port between NREQ requesters.
// Optional watchdog enabled by defining DDR_ARB_TIMEOUT_EN.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int ADDR_W         = ARB_ADDR_W,
  parameter int BLOCK_W        = ARB_BLOCK_W,
  parameter int WR_FIRST       = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*BLOCK_W-1:0] req_wdata,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [BLOCK_W-1:0]      rdata,
  output logic                    busy,
  output logic                    ram_en,
  output logic                    ram_write,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [BLOCK_W-1:0]      data_to_ram,
  input  logic                    ram_rdy,
  input  logic [BLOCK_W-1:0]      block_from_ram,
  output logic                    timeout_err
);

  localparam int PTR_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("ddr_port_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191) begin : g_bad_timeout
    $error("ddr_port_arbiter: TIMEOUT_CYCLES must fit the 13-bit watchdog");
  end

  state_t             state, next_state;
  logic [PTR_W-1:0]   rr_ptr, win_idx, next_ptr;
  logic [NREQ-1:0]    cand, wr_pend, win_onehot, grant_q;
  logic               load, finish, timed_out, tmo_hit;
  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [BLOCK_W-1:0] cmd_wdata;
  logic [ADDR_W-1:0]  addr_arr  [NREQ];
  logic [BLOCK_W-1:0] wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*BLOCK_W +: BLOCK_W];
  end

  // Write-first narrows the candidate set before the shared round-robin picker.
  assign wr_pend = req & req_write;
  assign cand    = ((WR_FIRST != 0) && (|wr_pend)) ? wr_pend : req;

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .cand (cand),
    .ptr  (rr_ptr),
    .win  (win_onehot)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_onehot[PTR_W'(i)]) win_idx = PTR_W'(i);
    end
  end

  assign next_ptr = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          load       = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (ram_rdy) begin
          finish     = 1'b1;
          next_state = DONE;
        end else if (tmo_hit) begin
          finish     = 1'b1;
          timed_out  = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant_q   <= '0;
      done      <= '0;
      rdata     <= '0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      done <= '0;
      if (load) begin
        grant_q   <= win_onehot;
        cmd_write <= |(req_write & win_onehot);
        cmd_addr  <= addr_arr[win_idx];
        cmd_wdata <= wdata_arr[win_idx];
        rr_ptr    <= next_ptr;
      end
      if (finish) begin
        done <= grant_q;
        if (timed_out)       rdata <= '0;
        else if (!cmd_write) rdata <= block_from_ram;
      end
      // Grant stays up through the done cycle and drops on the way back to IDLE.
      if (state == DONE) grant_q <= '0;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state != IDLE);
  assign ram_en      = (state == BUSY);
  assign ram_write   = cmd_write;
  assign ram_addr    = cmd_addr;
  assign data_to_ram = cmd_wdata;

`ifdef DDR_ARB_TIMEOUT_EN
  logic [12:0] tmo_cnt;
  logic        tmo_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (load)                tmo_cnt <= '0;
      else if (state == BUSY)  tmo_cnt <= tmo_cnt + 13'd1;
      if (timed_out)           tmo_flag <= 1'b1;
    end
  end

  // Count is zero in the first BUSY cycle, so the limit is hit in BUSY cycle TIMEOUT_CYCLES.
  assign tmo_hit     = (state == BUSY) && (tmo_cnt == 13'(TIMEOUT_CYCLES - 1));
  assign timeout_err = tmo_flag;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
